// File: rtl/pack_fp16_if.sv
// pack_fp16_if: input/output bundle for pack_fp16
// Ports: enable/in_valid + unpacked operand (master drives), out_valid/result (+flags when PACK_FP16_FLAGS_EN) back.
interface pack_fp16_if #(parameter int MANT_W = 14);
  logic              enable;
  logic              in_valid;
  logic              is_num;
  logic              is_nan;
  logic              is_pinf;
  logic              is_ninf;
  logic              sign_in;
  logic [6:0]        exp_in;
  logic [MANT_W-1:0] mant_in;
  logic              out_valid;
  logic [15:0]       result;
`ifdef PACK_FP16_FLAGS_EN
  logic              flag_inexact;
  logic              flag_overflow;
  logic              flag_underflow;
  modport master (output enable, in_valid, is_num, is_nan, is_pinf, is_ninf, sign_in, exp_in, mant_in,
                  input out_valid, result, flag_inexact, flag_overflow, flag_underflow);
  modport slave  (input enable, in_valid, is_num, is_nan, is_pinf, is_ninf, sign_in, exp_in, mant_in,
                  output out_valid, result, flag_inexact, flag_overflow, flag_underflow);
`else
  modport master (output enable, in_valid, is_num, is_nan, is_pinf, is_ninf, sign_in, exp_in, mant_in,
                  input out_valid, result);
  modport slave  (input enable, in_valid, is_num, is_nan, is_pinf, is_ninf, sign_in, exp_in, mant_in,
                  output out_valid, result);
`endif
endinterface

// File: rtl/pack_fp16.sv
// pack_fp16: 2-stage repack of unpacked sign/exp/mantissa into IEEE binary16 with RNE rounding
// Ports: clk, rst (sync, active-high), bus (pack_fp16_if.slave; MANT_W must match the interface).
// Optional PACK_FP16_FLAGS_EN adds registered flag_inexact/flag_overflow/flag_underflow.
module pack_fp16 #(
  parameter int MANT_W = 14
) (
  input logic        clk,
  input logic        rst,
  pack_fp16_if.slave bus
);
  typedef enum logic [1:0] {C_NUM, C_NAN, C_PINF, C_NINF} cls_t;
  logic              v1_q, v1_d, sgn1_q, sgn1_d, g1_q, g1_d, s1_q, s1_d, v2_q, v2_d;
  cls_t              cls1_q, cls1_d;
  logic [4:0]        ef1_q, ef1_d;
  logic [9:0]        fr1_q, fr1_d;
  logic [15:0]       res_q, res_d;
  logic signed [7:0] e_b;
  logic [7:0]        sh;
  logic              sub, zero, ovf, ru;
  logic [MANT_W-1:0] m_eff, lost;
  logic [14:0]       sum;
  // Overflow is pre-encoded as exponent 31 / fraction 0 with G=S=0 so stage 2 just adds zero.
  always_comb begin
    e_b    = $signed({bus.exp_in[6], bus.exp_in}) + 8'sd15;
    sub    = e_b < 8'sd1;
    sh     = 8'(8'sd1 - e_b);
    zero   = bus.mant_in == '0;
    ovf    = !zero && e_b > 8'sd30;
    m_eff  = sub ? bus.mant_in >> sh : bus.mant_in;
    lost   = sub ? bus.mant_in & ~({MANT_W{1'b1}} << sh) : '0;
    cls1_d = bus.is_nan ? C_NAN : bus.is_pinf ? C_PINF : bus.is_ninf ? C_NINF : bus.is_num ? C_NUM : C_NAN;
    v1_d   = bus.in_valid;
    sgn1_d = bus.sign_in;
    ef1_d  = (sub || zero) ? 5'h00 : ovf ? 5'h1F : e_b[4:0];
    fr1_d  = ovf ? 10'h000 : m_eff[MANT_W-2 -: 10];
    g1_d   = !ovf && m_eff[MANT_W-12];
    s1_d   = !ovf && (|m_eff[MANT_W-13:0] || |lost);
    ru     = g1_q & (s1_q | fr1_q[0]);
    sum    = {ef1_q, fr1_q} + 15'(ru);
    v2_d   = v1_q;
    res_d  = cls1_q == C_NAN ? 16'h7E00 : cls1_q == C_PINF ? 16'h7C00 : cls1_q == C_NINF ? 16'hFC00 : {sgn1_q, sum};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      sgn1_q <= 1'b0;
      cls1_q <= C_NUM;
      ef1_q  <= '0;
      fr1_q  <= '0;
      g1_q   <= 1'b0;
      s1_q   <= 1'b0;
      v2_q   <= 1'b0;
      res_q  <= '0;
    end else if (bus.enable) begin
      v1_q   <= v1_d;
      sgn1_q <= sgn1_d;
      cls1_q <= cls1_d;
      ef1_q  <= ef1_d;
      fr1_q  <= fr1_d;
      g1_q   <= g1_d;
      s1_q   <= s1_d;
      v2_q   <= v2_d;
      res_q  <= res_d;
    end
  end
  assign bus.out_valid = v2_q;
  assign bus.result    = res_q;
`ifdef PACK_FP16_FLAGS_EN
  logic ovf1_q, ovf1_d, fi_q, fi_d, fo_q, fo_d, fu_q, fu_d, fnum;
  // Saturation to infinity is always inexact even though G/S were zeroed.
  always_comb begin
    ovf1_d = ovf;
    fnum   = v1_q && cls1_q == C_NUM;
    fi_d   = fnum && (g1_q || s1_q || ovf1_q);
    fo_d   = fnum && sum[14:10] == 5'h1F;
    fu_d   = fnum && sum[14:10] == 5'h00 && (g1_q || s1_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf1_q <= 1'b0;
      fi_q   <= 1'b0;
      fo_q   <= 1'b0;
      fu_q   <= 1'b0;
    end else if (bus.enable) begin
      ovf1_q <= ovf1_d;
      fi_q   <= fi_d;
      fo_q   <= fo_d;
      fu_q   <= fu_d;
    end
  end
  assign bus.flag_inexact   = fi_q;
  assign bus.flag_overflow  = fo_q;
  assign bus.flag_underflow = fu_q;
`endif
endmodule

// File: tb/tb_pack_fp16.sv
// tb_pack_fp16: directed + random check of pack_fp16 against an exact-arithmetic binary16 rounding model
module tb_pack_fp16;
  localparam int MW = 14;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [16:0] q[$];
  pack_fp16_if #(.MANT_W(MW)) b ();
  pack_fp16 #(.MANT_W(MW)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  // Value = m * 2^(e-13); round to a multiple of the binary16 ulp with ties-to-even.
  function automatic logic [15:0] ref_pack(bit nan, bit pinf, bit ninf, bit num, bit s, int e, logic [MW-1:0] m);
    longint mm, qq, rem, half;
    int ulp, k;
    if (nan || !(pinf || ninf || num)) return 16'h7E00;
    if (pinf) return 16'h7C00;
    if (ninf) return 16'hFC00;
    if (m == 0) return {s, 15'h0000};
    if (e + 15 >= 31) return {s, 15'h7C00};
    mm   = longint'(m);
    ulp  = (e >= -14) ? e - 10 : -24;
    k    = ulp - (e - 13);
    qq   = mm >> k;
    rem  = mm - (qq << k);
    half = 64'd1 << (k - 1);
    if (rem > half || (rem == half && qq[0])) qq = qq + 1;
    if (e >= -14) qq = qq + (longint'(e + 14) << 10);
    if (qq >= 64'h7C00) return {s, 15'h7C00};
    return {s, qq[14:0]};
  endfunction
  task automatic check(string tag);
    logic [16:0] ex;
    ex = (q.size() == 2) ? q[0] : 17'h0;
    vectors++;
    assert (b.out_valid === ex[16]) else begin
      miscompares++;
      $error("FAIL %s out_valid: got %0b want %0b", tag, b.out_valid, ex[16]);
    end
    if (ex[16]) begin
      vectors++;
      assert (b.result === ex[15:0]) else begin
        miscompares++;
        $error("FAIL %s result: got %h want %h", tag, b.result, ex[15:0]);
      end
    end
  endtask
  task automatic step(bit en, bit iv, bit nan, bit pinf, bit ninf, bit num, bit s, int e, logic [MW-1:0] m, string tag);
    b.enable = en; b.in_valid = iv; b.is_nan = nan; b.is_pinf = pinf; b.is_ninf = ninf; b.is_num = num;
    b.sign_in = s; b.exp_in = 7'(e); b.mant_in = m;
    @(posedge clk); #1;
    if (en) begin
      q.push_back({iv, ref_pack(nan, pinf, ninf, num, s, e, m)});
      if (q.size() > 2) void'(q.pop_front());
    end
    check(tag);
  endtask
  task automatic num_beat(bit s, int e, logic [MW-1:0] m, string tag);
    step(1, 1, 0, 0, 0, 1, s, e, m, tag);
  endtask
  task automatic idle(bit en, string tag);
    step(en, 0, 0, 0, 0, 0, 0, 0, '0, tag);
  endtask
  task automatic do_reset(string tag);
    rst = 1'b1; b.enable = 1'b1; b.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    vectors += 2;
    assert (b.out_valid === 1'b0) else begin
      miscompares++;
      $error("FAIL %s out_valid: got %0b want 0", tag, b.out_valid);
    end
    assert (b.result === 16'h0000) else begin
      miscompares++;
      $error("FAIL %s result: got %h want 0000", tag, b.result);
    end
  endtask
  initial begin
    b.enable = 1'b0; b.in_valid = 1'b0; b.is_nan = 1'b0; b.is_pinf = 1'b0; b.is_ninf = 1'b0;
    b.is_num = 1'b0; b.sign_in = 1'b0; b.exp_in = '0; b.mant_in = '0;
    do_reset("reset");
    num_beat(0, 0, 14'b1_0000000000_000, "one_lat1");
    idle(1, "one");
    num_beat(0, 0, 14'b1_0000000001_100, "rne_up");
    num_beat(0, 0, 14'b1_0000000000_100, "rne_tie");
    num_beat(0, 0, 14'b1_0000000000_101, "rne_sticky");
    num_beat(0, 15, 14'b1_1111111111_111, "ovf_round");
    num_beat(1, 20, 14'b1_0000000000_000, "ovf_neg");
    num_beat(0, -15, 14'b1_0000000000_000, "sub_0200");
    num_beat(0, -24, 14'b1_0000000000_000, "sub_0001");
    num_beat(0, -25, 14'b1_0000000000_000, "sub_tie0");
    num_beat(0, -25, 14'b1_1000000000_000, "sub_up1");
    num_beat(0, -60, 14'b1_0000000000_000, "sub_deep");
    num_beat(0, -15, 14'b1_1111111111_100, "sub_carry");
    step(1, 1, 1, 0, 0, 0, 1, 3, 14'h2abc, "nan");
    step(1, 1, 0, 0, 1, 0, 0, 0, '0, "ninf");
    step(1, 1, 0, 1, 0, 0, 1, 0, '0, "pinf");
    num_beat(1, 5, '0, "neg_zero");
    step(1, 1, 1, 1, 1, 1, 0, 0, 14'h2000, "all_flags");
    step(1, 1, 0, 0, 0, 0, 1, 0, 14'h2000, "no_class");
    idle(1, "drain0");
    idle(1, "drain1");
    num_beat(0, 1, 14'h2800, "bb0");
    num_beat(1, -3, 14'h3abc, "bb1");
    num_beat(0, 14, 14'h3fff, "bb2");
    for (int i = 0; i < 3; i++) idle(0, "stall");
    for (int i = 0; i < 3; i++) idle(1, "after_stall");
    num_beat(0, 2, 14'h2400, "inflight0");
    num_beat(1, 7, 14'h3100, "inflight1");
    do_reset("mid_reset");
    for (int i = 0; i < 3; i++) idle(1, "post_reset");
    for (int i = 0; i < 400; i++) begin
      int c, e;
      bit en, iv;
      logic [MW-1:0] m;
      en = $urandom_range(0, 4) != 0;
      iv = $urandom_range(0, 4) != 0;
      c  = $urandom_range(0, 15);
      e  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 127) - 64 : $urandom_range(0, 50) - 32;
      m  = ($urandom_range(0, 9) == 0) ? '0 : {1'b1, 13'($urandom)};
      step(en, iv, c == 0 || c == 4, c == 1 || c == 4, c == 2, c >= 4, 1'($urandom), e, m, "random");
    end
    idle(1, "final0");
    idle(1, "final1");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
